// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: 256x16 program memory, 8x16 register file, FETCH/EXEC/WB pipeline.
// Optional macro INSTR_SEQ_SAT_EN selects saturating arithmetic; otherwise results wrap.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [15:0] load_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  pc,
    output logic [15:0] result,
    output logic        result_valid,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SUBI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic [15:0] imem_r [0:255];
    logic [15:0] rf_r   [0:7];

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [7:0]  pc_r;
    logic [15:0] ir_r;
    logic [15:0] alu_r;
    logic        wr_en_r;
    logic [15:0] result_r;
    logic        result_valid_r;
    logic        busy_r;
    logic        done_r;

    logic [2:0]  op_s;
    logic [2:0]  ra_s;
    logic [2:0]  rb_s;
    logic [2:0]  rc_s;
    logic [15:0] imm_s;
    logic [15:0] alu_s;
    logic        wr_s;

    // Subtraction is a + ~b + 1; overflow means equal operand signs giving a result of the other sign.
    function automatic logic [15:0] arith(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [15:0] bb;
        logic [15:0] sum;
        bb  = sub ? ~b : b;
        sum = a + bb + {15'd0, sub};
`ifdef INSTR_SEQ_SAT_EN
        if ((a[15] == bb[15]) && (sum[15] != a[15])) begin
            sum = a[15] ? 16'h8000 : 16'h7FFF;
        end
`endif
        return sum;
    endfunction

    assign op_s  = ir_r[15:13];
    assign ra_s  = ir_r[12:10];
    assign rb_s  = ir_r[9:7];
    assign rc_s  = ir_r[6:4];
    assign imm_s = {{9{ir_r[6]}}, ir_r[6:0]};

    // ALU: operands are read from the register file as it stands before writeback
    always_comb begin
        alu_s = 16'h0000;
        wr_s  = 1'b0;
        case (op_s)
            OP_ADD: begin
                alu_s = arith(rf_r[rb_s], rf_r[rc_s], 1'b0);
                wr_s  = 1'b1;
            end
            OP_ADDI: begin
                alu_s = arith(rf_r[rb_s], imm_s, 1'b0);
                wr_s  = 1'b1;
            end
            OP_SUBI: begin
                alu_s = arith(rf_r[rb_s], imm_s, 1'b1);
                wr_s  = 1'b1;
            end
            OP_SUB: begin
                alu_s = arith(rf_r[rb_s], rf_r[rc_s], 1'b1);
                wr_s  = 1'b1;
            end
            default: begin
                alu_s = 16'h0000;
                wr_s  = 1'b0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: state_nxt_s = ST_EXEC;
            ST_EXEC: begin
                if (op_s == OP_HALT) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_WB: begin
                if (pc_r == 8'hFF) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control state, PC, instruction/holding registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            pc_r           <= 8'h00;
            ir_r           <= 16'h0000;
            alu_r          <= 16'h0000;
            wr_en_r        <= 1'b0;
            result_r       <= 16'h0000;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            busy_r         <= (state_nxt_s != ST_IDLE);
            done_r         <= (state_nxt_s == ST_DONE);
            result_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        pc_r <= 8'h00;
                    end
                end
                ST_FETCH: ir_r <= imem_r[pc_r];
                ST_EXEC: begin
                    alu_r   <= alu_s;
                    wr_en_r <= wr_s;
                    // result/result_valid are set on entry to WB so they are presented during WB
                    if (wr_s) begin
                        result_r       <= alu_s;
                        result_valid_r <= 1'b1;
                    end
                end
                ST_WB: begin
                    if (pc_r != 8'hFF) begin
                        pc_r <= pc_r + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register file: cleared by reset, written at the end of WB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rf_r[i] <= 16'h0000;
            end
        end else if ((state_r == ST_WB) && wr_en_r) begin
            rf_r[ra_s] <= alu_r;
        end
    end

    // Instruction memory survives reset so a program can be re-run afterwards
    always_ff @(posedge clk) begin
        if ((state_r == ST_IDLE) && load_en) begin
            imem_r[load_addr] <= load_data;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign pc           = pc_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign dbg_data     = rf_r[dbg_addr];

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: scoreboard of writebacks fed by an instruction-level reference model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  pc;
    logic [15:0] result;
    logic        result_valid;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .busy(busy), .done(done), .pc(pc),
        .result(result), .result_valid(result_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

`ifdef INSTR_SEQ_SAT_EN
    localparam logic [15:0] EXP_DOUBLE_MAX = 16'h7FFF;
`else
    localparam logic [15:0] EXP_DOUBLE_MAX = 16'hFFFE;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] m_imem [256];
    logic [15:0] m_rf   [8];
    logic [15:0] exp_q  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [6:0] low);
        return {op, ra, rb, low};
    endfunction

    // 16-bit two's complement sum of two mathematical integers
    function automatic logic [15:0] m_add(input int a, input int b);
        int s;
        s = a + b;
`ifdef INSTR_SEQ_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    // Executes the program in m_imem one instruction at a time and queues expected writebacks
    task automatic model_run(output int cycles, output int fpc);
        int          p;
        int          n;
        int          a;
        int          b;
        bit          fin;
        logic [15:0] w;
        logic [2:0]  op;
        logic [15:0] res;
        p = 0; n = 0; fin = 0; cycles = 0;
        while (!fin) begin
            w  = m_imem[p];
            op = w[15:13];
            if (op == 3'b111) begin
                cycles = 3 * n + 2;
                fin = 1;
            end else begin
                a = int'($signed(m_rf[w[9:7]]));
                case (op)
                    3'b000:  b = int'($signed(m_rf[w[6:4]]));
                    3'b001:  b = int'($signed(w[6:0]));
                    3'b010:  b = -int'($signed(w[6:0]));
                    3'b011:  b = -int'($signed(m_rf[w[6:4]]));
                    default: b = 0;
                endcase
                if (op <= 3'b011) begin
                    res = m_add(a, b);
                    m_rf[w[12:10]] = res;
                    exp_q.push_back(res);
                end
                n++;
                if (p == 255) begin
                    cycles = 3 * n;
                    fin = 1;
                end else begin
                    p++;
                end
            end
        end
        fpc = p;
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        load_en = 1'b1;
        load_addr = a[7:0];
        load_data = d;
        tick();
        load_en = 1'b0;
        m_imem[a] = d;
    endtask

    task automatic check_reg(input string name, input int r, input logic [15:0] exp);
        dbg_addr = r[2:0];
        #1;
        check(name, dbg_data, exp);
    endtask

    // Starts the program, pokes start/load_en while busy, then checks latency, pc and registers
    task automatic run_program(input string tag);
        int exp_cyc;
        int exp_pc;
        int cyc;
        model_run(exp_cyc, exp_pc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        check($sformatf("%s busy", tag), busy, 1);
        while (!done && cyc < 1000) begin
            if (cyc == 4) begin
                start = 1'b1; load_en = 1'b1; load_addr = 8'h00; load_data = 16'($urandom);
            end else begin
                start = 1'b0; load_en = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0; load_en = 1'b0;
        check($sformatf("%s done latency", tag), cyc, exp_cyc);
        check($sformatf("%s final pc", tag), pc, exp_pc);
        tick();
        check($sformatf("%s done pulse width", tag), done, 0);
        check($sformatf("%s idle busy", tag), busy, 0);
        check($sformatf("%s pending writebacks", tag), exp_q.size(), 0);
        exp_q.delete();
        for (int r = 0; r < 8; r++) begin
            check_reg($sformatf("%s r%0d", tag, r), r, m_rf[r]);
        end
    endtask

    // Scoreboard monitor: every result_valid must match the oldest expected writeback
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected result_valid: result=%0h, expected no writeback", result);
            end else if (result !== exp_q[0]) begin
                miscompares++;
                $display("FAIL writeback result: got %0h, expected %0h", result, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; load_en = 1'b0; load_addr = 8'h00; load_data = 16'h0000;
        start = 1'b0; dbg_addr = 3'd0;
        for (int r = 0; r < 8; r++) m_rf[r] = 16'h0000;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset pc", pc, 0);
        check("reset result", result, 0);
        check("reset result_valid", result_valid, 0);
        for (int r = 0; r < 8; r++) check_reg($sformatf("reset r%0d", r), r, 16'h0000);

        // 256 NOPs: runs off the end of memory, pc must park at 255
        for (int i = 0; i < 256; i++) load_word(i, 16'h8000);
        run_program("nop256");
        tick(); tick();
        check("nop256 pc held", pc, 8'hFF);

        load_word(0, enc(3'b001, 3'd1, 3'd0, 7'd5));
        load_word(1, enc(3'b001, 3'd2, 3'd0, 7'd3));
        load_word(2, enc(3'b000, 3'd3, 3'd1, {3'd2, 4'd0}));
        load_word(3, 16'hE000);
        run_program("add3");
        check_reg("add3 r3 const", 3, 16'd8);
        check("add3 pc const", pc, 8'd3);

        load_word(0, enc(3'b001, 3'd1, 3'd0, 7'h7F));
        load_word(1, enc(3'b010, 3'd2, 3'd1, 7'h40));
        load_word(2, 16'hE000);
        run_program("neg_imm");
        check_reg("neg_imm r1 const", 1, 16'hFFFF);
        check_reg("neg_imm r2 const", 2, 16'h003F);

        // Build 0x7FFF in r3, then double it into r4 to hit signed overflow
        load_word(0, enc(3'b001, 3'd1, 3'd0, 7'd1));
        for (int i = 1; i <= 14; i++) load_word(i, enc(3'b000, 3'd1, 3'd1, {3'd1, 4'd0}));
        load_word(15, enc(3'b010, 3'd2, 3'd1, 7'd1));
        load_word(16, enc(3'b000, 3'd3, 3'd1, {3'd2, 4'd0}));
        load_word(17, enc(3'b000, 3'd4, 3'd3, {3'd3, 4'd0}));
        load_word(18, 16'hE000);
        run_program("overflow");
        check_reg("overflow r3 const", 3, 16'h7FFF);
        check_reg("overflow r4 const", 4, EXP_DOUBLE_MAX);

        // Reset during EXEC of the first instruction: no writeback, program preserved
        load_word(0, enc(3'b001, 3'd1, 3'd0, 7'd9));
        load_word(1, 16'hE000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        for (int r = 0; r < 8; r++) m_rf[r] = 16'h0000;
        check("abort busy", busy, 0);
        check("abort pc", pc, 0);
        check("abort result_valid", result_valid, 0);
        check("abort done", done, 0);
        check_reg("abort r1", 1, 16'h0000);
        rst_n = 1'b1;
        tick();
        run_program("rerun");
        check_reg("rerun r1 const", 1, 16'd9);

        for (int t = 0; t < 6; t++) begin
            int          len;
            int          sel;
            logic [12:0] fields;
            logic [2:0]  op;
            len = $urandom_range(5, 30);
            for (int i = 0; i < len; i++) begin
                sel = $urandom_range(0, 6);
                op = 3'(sel);
                fields = 13'($urandom);
                load_word(i, {op, fields});
            end
            load_word(len, 16'hE000);
            run_program($sformatf("random%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
